// File: rtl/ysyx_041461_exe_mdu.sv
// Iterative RV64M multiply/divide unit for the EXE stage.
// Shift-add multiply and restoring divide, one bit per cycle; W ops run 32 iterations.
module ysyx_041461_exe_mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdu_valid_in,
    input  logic [3:0]  mdu_op_in,
    input  logic [63:0] mdu_src1_in,
    input  logic [63:0] mdu_src2_in,
    input  logic        mdu_flush,
    output logic        mdu_stall,
    output logic        mdu_out_valid,
    output logic [63:0] mdu_result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    typedef enum logic [3:0] {
        OP_MUL = 4'd0, OP_MULH = 4'd1, OP_MULHSU = 4'd2, OP_MULHU = 4'd3,
        OP_DIV = 4'd4, OP_DIVU = 4'd5, OP_REM = 4'd6, OP_REMU = 4'd7,
        OP_MULW = 4'd8, OP_DIVW = 4'd9, OP_DIVUW = 4'd10, OP_REMW = 4'd11,
        OP_REMUW = 4'd12
    } op_t;

    state_t         state_q;
    logic [6:0]     cnt_q;
    logic [127:0]   acc_q;
    logic [63:0]    opb_q;
    logic [3:0]     op_q;
    logic           neg_q;
    logic [63:0]    result_q;
    logic           out_valid_q;

    function automatic logic is_w(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd12);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return ((op >= 4'd4) && (op <= 4'd7)) || ((op >= 4'd9) && (op <= 4'd12));
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Final accumulator to architectural result, including sign fix-up.
    function automatic logic [63:0] select_result(input logic [3:0] op, input logic neg,
                                                  input logic [127:0] acc);
        logic [127:0] p;
        logic [63:0]  v;
        logic [31:0]  v32;
        p   = neg ? (~acc + 128'd1) : acc;
        v   = '0;
        v32 = '0;
        case (op)
            OP_MUL:                        v = acc[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  v = p[127:64];
            OP_DIV, OP_DIVU:               v = neg ? (~acc[63:0] + 64'd1) : acc[63:0];
            OP_REM, OP_REMU:               v = neg ? (~acc[127:64] + 64'd1) : acc[127:64];
            OP_MULW:                       v = sext32(acc[63:32]);
            OP_DIVW, OP_DIVUW: begin
                v32 = neg ? (~acc[31:0] + 32'd1) : acc[31:0];
                v   = sext32(v32);
            end
            OP_REMW, OP_REMUW: begin
                v32 = neg ? (~acc[95:64] + 32'd1) : acc[95:64];
                v   = sext32(v32);
            end
            default:                       v = '0;
        endcase
        return v;
    endfunction

    // Start-of-op operand conditioning and short-circuit detection
    logic        sg1, sg2, s1, s2, w_in, div_in, rsv_in;
    logic [63:0] x1, x2, mag1, mag2, dvd_ext;
    logic        div_zero, div_ovf, short_d, neg_d;
    logic [63:0] short_res_d;
    logic [127:0] acc_init_d;
    logic [63:0]  opb_init_d;

    always_comb begin
        w_in   = is_w(mdu_op_in);
        div_in = is_div(mdu_op_in);
        rsv_in = mdu_op_in >= 4'd13;
        sg1 = (mdu_op_in == OP_MULH) || (mdu_op_in == OP_MULHSU) || (mdu_op_in == OP_DIV) ||
              (mdu_op_in == OP_REM) || (mdu_op_in == OP_DIVW) || (mdu_op_in == OP_REMW);
        sg2 = (mdu_op_in == OP_MULH) || (mdu_op_in == OP_DIV) || (mdu_op_in == OP_REM) ||
              (mdu_op_in == OP_DIVW) || (mdu_op_in == OP_REMW);
        x1 = mdu_src1_in;
        x2 = mdu_src2_in;
        if (w_in) begin
            x1 = sg1 ? sext32(mdu_src1_in[31:0]) : {32'd0, mdu_src1_in[31:0]};
            x2 = sg2 ? sext32(mdu_src2_in[31:0]) : {32'd0, mdu_src2_in[31:0]};
        end
        s1    = sg1 & x1[63];
        s2    = sg2 & x2[63];
        mag1  = s1 ? (~x1 + 64'd1) : x1;
        mag2  = s2 ? (~x2 + 64'd1) : x2;
        neg_d = is_rem(mdu_op_in) ? s1 : (s1 ^ s2);
        dvd_ext  = w_in ? sext32(mdu_src1_in[31:0]) : mdu_src1_in;
        div_zero = div_in && (x2 == '0);
        div_ovf  = div_in && sg1 && (w_in ? ((mdu_src1_in[31:0] == 32'h8000_0000) &&
                                             (mdu_src2_in[31:0] == '1))
                                          : ((mdu_src1_in == 64'h8000_0000_0000_0000) &&
                                             (mdu_src2_in == '1)));
        short_d     = rsv_in || div_zero || div_ovf;
        short_res_d = '0;
        if (div_zero)
            short_res_d = is_rem(mdu_op_in) ? dvd_ext : '1;
        else if (div_ovf)
            short_res_d = is_rem(mdu_op_in) ? '0 : dvd_ext;
        if (div_in) begin
            acc_init_d = w_in ? {64'd0, mag1[31:0], 32'd0} : {64'd0, mag1};
            opb_init_d = mag2;
        end else begin
            acc_init_d = {64'd0, mag2};
            opb_init_d = mag1;
        end
    end

    // One iteration of the active algorithm
    logic [64:0]  mul_sum;
    logic [65:0]  div_diff;
    logic [127:0] acc_d;
    logic         last_iter;

    always_comb begin
        mul_sum  = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opb_q} : 65'd0);
        div_diff = {1'b0, acc_q[127:63]} - {2'b0, opb_q};
        if (is_div(op_q))
            acc_d = div_diff[65] ? {acc_q[126:0], 1'b0} : {div_diff[63:0], acc_q[62:0], 1'b1};
        else
            acc_d = {mul_sum, acc_q[63:1]};
        last_iter = cnt_q == (is_w(op_q) ? 7'd31 : 7'd63);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (mdu_flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mdu_valid_in) begin
                        op_q  <= mdu_op_in;
                        neg_q <= neg_d;
                        cnt_q <= '0;
                        if (short_d) begin
                            result_q    <= short_res_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            acc_q   <= acc_init_d;
                            opb_q   <= opb_init_d;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 7'd1;
                    if (last_iter) begin
                        result_q    <= select_result(op_q, neg_q, acc_d);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mdu_stall     = mdu_valid_in & ~mdu_flush & (state_q != S_DONE);
    assign mdu_out_valid = out_valid_q;
    assign mdu_result    = result_q;

endmodule

// File: tb/tb_ysyx_041461_exe_mdu.sv
// Directed self-checking bench for ysyx_041461_exe_mdu.
module tb_ysyx_041461_exe_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdu_valid_in = 1'b0;
    logic [3:0]  mdu_op_in = '0;
    logic [63:0] mdu_src1_in = '0;
    logic [63:0] mdu_src2_in = '0;
    logic        mdu_flush = 1'b0;
    logic        mdu_stall;
    logic        mdu_out_valid;
    logic [63:0] mdu_result;

    int nvec = 0;
    int nerr = 0;

    ysyx_041461_exe_mdu dut (
        .clk(clk), .rst(rst), .mdu_valid_in(mdu_valid_in), .mdu_op_in(mdu_op_in),
        .mdu_src1_in(mdu_src1_in), .mdu_src2_in(mdu_src2_in), .mdu_flush(mdu_flush),
        .mdu_stall(mdu_stall), .mdu_out_valid(mdu_out_valid), .mdu_result(mdu_result)
    );

    always #5 clk = ~clk;

    // Presents an op at the start of a cycle and watches it until mdu_out_valid.
    // Returns with the DONE cycle in progress and mdu_valid_in still high.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat, output int stalls,
                          output logic first_stall);
        int  cyc;
        bit  done;
        @(posedge clk); #1;
        mdu_valid_in = 1'b1; mdu_op_in = op; mdu_src1_in = a; mdu_src2_in = b; mdu_flush = 1'b0;
        cyc = 0; stalls = 0; lat = -1; res = 'x; done = 1'b0;
        @(negedge clk);
        first_stall = mdu_stall;
        while (!done) begin
            if (mdu_stall) stalls++;
            if (mdu_out_valid === 1'b1) begin
                res = mdu_result; lat = cyc; done = 1'b1;
            end else if (cyc >= 200) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic end_op();
        @(posedge clk); #1;
        mdu_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (mdu_stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", mdu_stall); end
        nvec++; if (mdu_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", mdu_out_valid); end
        nvec++; if (mdu_result !== 64'd0) begin nerr++; $display("FAIL reset_result got %h want 0", mdu_result); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if (mdu_stall !== 1'b0) begin nerr++; $display("FAIL idle_stall got %b want 0", mdu_stall); end
    endtask

    task automatic test_mul_latency();
        logic [63:0] r; int lat, st; logic fs;
        run_op(4'd0, 64'd7, -64'sd3, r, lat, st, fs);
        end_op();
        nvec++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin nerr++; $display("FAIL mul_result got %h want FFFFFFFFFFFFFFEB", r); end
        nvec++; if (lat != 65) begin nerr++; $display("FAIL mul_latency got %0d want 65", lat); end
        nvec++; if (st != 65) begin nerr++; $display("FAIL mul_stall_cycles got %0d want 65", st); end
        @(negedge clk);
        nvec++; if (mdu_out_valid !== 1'b0) begin nerr++; $display("FAIL mul_valid_pulse got %b want 0", mdu_out_valid); end
    endtask

    task automatic test_mulh_variants();
        logic [3:0]  ops [3] = '{4'd1, 4'd3, 4'd2};
        logic [63:0] as  [3] = '{64'h8000_0000_0000_0000, '1, '1};
        logic [63:0] bs  [3] = '{64'h8000_0000_0000_0000, 64'd2, 64'd2};
        logic [63:0] ex  [3] = '{64'h4000_0000_0000_0000, 64'd1, '1};
        logic [63:0] r; int lat, st; logic fs;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat, st, fs);
            end_op();
            nvec++; if (r !== ex[i]) begin nerr++; $display("FAIL mulh_%0d got %h want %h", i, r, ex[i]); end
            nvec++; if (lat != 65) begin nerr++; $display("FAIL mulh_lat_%0d got %0d want 65", i, lat); end
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops [4] = '{4'd4, 4'd6, 4'd5, 4'd7};
        logic [63:0] as  [4] = '{-64'sd7, -64'sd7, 64'd100, 64'd100};
        logic [63:0] bs  [4] = '{64'd2, 64'd2, 64'd7, 64'd7};
        logic [63:0] ex  [4] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd14, 64'd2};
        logic [63:0] r; int lat, st; logic fs;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat, st, fs);
            end_op();
            nvec++; if (r !== ex[i]) begin nerr++; $display("FAIL div_%0d got %h want %h", i, r, ex[i]); end
            nvec++; if (lat != 65) begin nerr++; $display("FAIL div_lat_%0d got %0d want 65", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [3:0]  ops [6] = '{4'd4, 4'd7, 4'd4, 4'd6, 4'd9, 4'd13};
        logic [63:0] as  [6] = '{64'd1234, 64'd5, 64'h8000_0000_0000_0000,
                                 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000, 64'd9};
        logic [63:0] bs  [6] = '{64'd0, 64'd0, '1, '1, '1, 64'd3};
        logic [63:0] ex  [6] = '{'1, 64'd5, 64'h8000_0000_0000_0000, 64'd0,
                                 64'hFFFF_FFFF_8000_0000, 64'd0};
        logic [63:0] r; int lat, st; logic fs;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat, st, fs);
            end_op();
            nvec++; if (r !== ex[i]) begin nerr++; $display("FAIL special_%0d got %h want %h", i, r, ex[i]); end
            nvec++; if (lat != 1) begin nerr++; $display("FAIL special_lat_%0d got %0d want 1", i, lat); end
            nvec++; if (st != 1) begin nerr++; $display("FAIL special_stall_%0d got %0d want 1", i, st); end
        end
    endtask

    task automatic test_w_ops();
        logic [3:0]  ops [4] = '{4'd8, 4'd10, 4'd9, 4'd12};
        logic [63:0] as  [4] = '{64'h0000_0000_7FFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                                 64'h0000_0000_FFFF_FFF9, 64'h1234_5678_FFFF_FFFF};
        logic [63:0] bs  [4] = '{64'd2, 64'd1, 64'd2, 64'd16};
        logic [63:0] ex  [4] = '{64'hFFFF_FFFF_FFFF_FFFE, '1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd15};
        logic [63:0] r; int lat, st; logic fs;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat, st, fs);
            end_op();
            nvec++; if (r !== ex[i]) begin nerr++; $display("FAIL w_%0d got %h want %h", i, r, ex[i]); end
            nvec++; if (lat != 33) begin nerr++; $display("FAIL w_lat_%0d got %0d want 33", i, lat); end
            nvec++; if (st != 33) begin nerr++; $display("FAIL w_stall_%0d got %0d want 33", i, st); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] r; int lat, st; logic fs;
        @(posedge clk); #1;
        mdu_valid_in = 1'b1; mdu_op_in = 4'd0; mdu_src1_in = 64'd5; mdu_src2_in = 64'd6;
        repeat (21) @(posedge clk);
        #1 mdu_flush = 1'b1;
        @(negedge clk);
        nvec++; if (mdu_stall !== 1'b0) begin nerr++; $display("FAIL flush_stall got %b want 0", mdu_stall); end
        nvec++; if (mdu_out_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid got %b want 0", mdu_out_valid); end
        run_op(4'd0, 64'd3, 64'd4, r, lat, st, fs);
        end_op();
        nvec++; if (fs !== 1'b1) begin nerr++; $display("FAIL flush_restart_stall got %b want 1", fs); end
        nvec++; if (r !== 64'd12) begin nerr++; $display("FAIL flush_restart_result got %h want c", r); end
        nvec++; if (lat != 65) begin nerr++; $display("FAIL flush_restart_lat got %0d want 65", lat); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; int lat, st; logic fs;
        int seen;
        @(posedge clk); #1;
        mdu_valid_in = 1'b1; mdu_op_in = 4'd5; mdu_src1_in = 64'd100; mdu_src2_in = 64'd7;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1; mdu_valid_in = 1'b0;
        @(negedge clk);
        nvec++; if (mdu_stall !== 1'b0) begin nerr++; $display("FAIL rstmid_stall got %b want 0", mdu_stall); end
        nvec++; if (mdu_out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_valid got %b want 0", mdu_out_valid); end
        nvec++; if (mdu_result !== 64'd0) begin nerr++; $display("FAIL rstmid_result got %h want 0", mdu_result); end
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (mdu_out_valid === 1'b1) seen++;
        end
        nvec++; if (seen != 0) begin nerr++; $display("FAIL rstmid_discard got %0d valid cycles want 0", seen); end
        run_op(4'd5, 64'd100, 64'd7, r, lat, st, fs);
        end_op();
        nvec++; if (r !== 64'd14) begin nerr++; $display("FAIL rstmid_after got %h want e", r); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r; int lat, st; logic fs;
        run_op(4'd5, 64'd100, 64'd7, r, lat, st, fs);
        nvec++; if (r !== 64'd14) begin nerr++; $display("FAIL b2b_first got %h want e", r); end
        run_op(4'd5, 64'd1000, 64'd10, r, lat, st, fs);
        end_op();
        nvec++; if (fs !== 1'b1) begin nerr++; $display("FAIL b2b_start_stall got %b want 1", fs); end
        nvec++; if (r !== 64'd100) begin nerr++; $display("FAIL b2b_second got %h want 64", r); end
        nvec++; if (lat != 65) begin nerr++; $display("FAIL b2b_lat got %0d want 65", lat); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_mulh_variants();
        test_div();
        test_special();
        test_w_ops();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
